// File: rtl/cpu_sys_timebase_irq_pkg.sv
// Shared definitions for the per-core timebase and interrupt conditioner.
// Holds the system counter width, the default PLIC bus width and the
// counter value type used by the top level.

package cpu_sys_pkg;

  // Width of the architectural system counter seen by the core.
  localparam int SYS_CNT_W = 64;

  // Default width of the PLIC valid/config buses.
  localparam int PLIC_W_DEF = 240;

  // System counter value type.
  typedef logic [SYS_CNT_W-1:0] sys_cnt_t;

  // Width needed to hold a counter that runs 0..(n-1); never below 1 bit.
  function automatic int cntWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cpu_sys_timebase_irq_cond.sv
// Single interrupt channel conditioner.
// An asynchronous source is brought into the core clock domain through a
// flop chain, then a history flop allows rising-edge detection. The output
// is registered, so the source-to-valid latency is SYNC_STAGES+1 cycles.

module cpu_irq_cond #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_b,
  input  logic i_async_irq,
  input  logic i_pulse_mode,
  output logic o_vld
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;
  logic                   r_vld;
  logic                   w_syncLevel;
  logic                   w_rise;
  logic                   w_vldNext;

  assign w_syncLevel = r_sync[SYNC_STAGES-1];
  assign w_rise      = w_syncLevel & ~r_hist;

  // Select level or rising-edge behaviour for the next registered valid.
  always_comb begin
    w_vldNext = w_syncLevel;
    if (i_pulse_mode) begin
      w_vldNext = w_rise;
    end
  end

  // Synchroniser chain, history flop (updated in both modes so a mode switch
  // never creates a stale edge) and the registered valid output.
  always_ff @(posedge i_clk) begin
    if (!i_rst_b) begin
      r_sync <= '0;
      r_hist <= 1'b0;
      r_vld  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async_irq};
      r_hist <= w_syncLevel;
      r_vld  <= w_vldNext;
    end
  end

  assign o_vld = r_vld;

endmodule

// File: rtl/cpu_sys_timebase_irq.sv
// Per-core system timebase and interrupt conditioner.
// Provides the 64-bit system counter with prescaler, load and sticky compare
// interrupt, a free-running divided APB clock with its enable pulse, and the
// conditioned external interrupt buses towards the PLIC.

module cpu_sys_timebase_irq
  import cpu_sys_pkg::*;
#(
  parameter int N_IRQ       = 40,
  parameter int PLIC_W      = PLIC_W_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int PRE_W       = 16,
  parameter int APB_HALF    = 1
) (
  input  logic                 i_pll_core_cpuclk,
  input  logic                 i_pad_cpu_rst_b,
  input  logic                 i_cnt_en,
  input  logic                 i_cnt_load,
  input  logic [SYS_CNT_W-1:0] i_cnt_load_val,
  input  logic [PRE_W-1:0]     i_prescale_div,
  input  logic [SYS_CNT_W-1:0] i_cmp_val,
  input  logic                 i_cmp_irq_clr,
  input  logic [N_IRQ-1:0]     i_irq_pulse_mode,
  input  logic [N_IRQ-1:0]     i_xx_intc_int,
  output logic [SYS_CNT_W-1:0] o_pad_cpu_sys_cnt,
  output logic                 o_cnt_tick,
  output logic                 o_cmp_irq,
  output logic                 o_sys_apb_clk,
  output logic                 o_sys_apb_clk_en,
  output logic [PLIC_W-1:0]    o_pad_plic_int_vld,
  output logic [PLIC_W-1:0]    o_pad_plic_int_cfg
);

  localparam int APB_W = cntWidth(APB_HALF);
  localparam logic [APB_W-1:0] APB_LAST = APB_W'(APB_HALF - 1);

  // ---------------------------------------------------------------------
  // Timebase: prescaler + 64-bit counter
  // ---------------------------------------------------------------------
  logic [PRE_W-1:0] r_preCnt;
  sys_cnt_t         r_sysCnt;
  logic             r_tick;
  logic             w_preHit;

  // A tick is due once the prescaler has reached (or passed) the divide value,
  // so lowering the divide value below the current count ticks immediately.
  assign w_preHit = (r_preCnt >= i_prescale_div);

  // Prescaler and counter update; a load overrides any increment that cycle.
  always_ff @(posedge i_pll_core_cpuclk) begin
    if (!i_pad_cpu_rst_b) begin
      r_preCnt <= '0;
      r_sysCnt <= '0;
      r_tick   <= 1'b0;
    end else if (i_cnt_load) begin
      r_preCnt <= '0;
      r_sysCnt <= i_cnt_load_val;
      r_tick   <= 1'b0;
    end else if (i_cnt_en) begin
      if (w_preHit) begin
        r_preCnt <= '0;
        r_sysCnt <= r_sysCnt + sys_cnt_t'(1);
        r_tick   <= 1'b1;
      end else begin
        r_preCnt <= r_preCnt + PRE_W'(1);
        r_tick   <= 1'b0;
      end
    end else begin
      r_tick <= 1'b0;
    end
  end

  assign o_pad_cpu_sys_cnt = r_sysCnt;
  assign o_cnt_tick        = r_tick;

  // ---------------------------------------------------------------------
  // Compare interrupt
  // ---------------------------------------------------------------------
  logic r_cmpIrq;
  logic w_cmpHit;

  assign w_cmpHit = (r_sysCnt == i_cmp_val);

  // Sticky compare flag; a new match beats a simultaneous clear.
  always_ff @(posedge i_pll_core_cpuclk) begin
    if (!i_pad_cpu_rst_b) begin
      r_cmpIrq <= 1'b0;
    end else if (w_cmpHit) begin
      r_cmpIrq <= 1'b1;
    end else if (i_cmp_irq_clr) begin
      r_cmpIrq <= 1'b0;
    end
  end

  assign o_cmp_irq = r_cmpIrq;

  // ---------------------------------------------------------------------
  // APB clock divider
  // ---------------------------------------------------------------------
  logic [APB_W-1:0] r_apbDiv;
  logic             r_apbClk;
  logic             r_apbEn;
  logic [APB_W-1:0] w_apbDivNext;
  logic             w_apbClkNext;
  logic             w_apbEnNext;

  // Next divider state; the enable is computed one step ahead so that the
  // registered pulse sits in the cycle just before the 0->1 toggle.
  always_comb begin
    w_apbDivNext = r_apbDiv + APB_W'(1);
    w_apbClkNext = r_apbClk;
    if (r_apbDiv == APB_LAST) begin
      w_apbDivNext = '0;
      w_apbClkNext = ~r_apbClk;
    end
    w_apbEnNext = (w_apbDivNext == APB_LAST) && !w_apbClkNext;
  end

  // Free-running divider state, independent of the counter enable.
  always_ff @(posedge i_pll_core_cpuclk) begin
    if (!i_pad_cpu_rst_b) begin
      r_apbDiv <= '0;
      r_apbClk <= 1'b0;
      r_apbEn  <= 1'b0;
    end else begin
      r_apbDiv <= w_apbDivNext;
      r_apbClk <= w_apbClkNext;
      r_apbEn  <= w_apbEnNext;
    end
  end

  assign o_sys_apb_clk    = r_apbClk;
  assign o_sys_apb_clk_en = r_apbEn;

  // ---------------------------------------------------------------------
  // External interrupt conditioning
  // ---------------------------------------------------------------------
  logic [N_IRQ-1:0] w_irqVld;

  for (genvar g = 0; g < N_IRQ; g++) begin : gen_irq
    cpu_irq_cond #(
      .SYNC_STAGES (SYNC_STAGES)
    ) u_irq_cond (
      .i_clk        (i_pll_core_cpuclk),
      .i_rst_b      (i_pad_cpu_rst_b),
      .i_async_irq  (i_xx_intc_int[g]),
      .i_pulse_mode (i_irq_pulse_mode[g]),
      .o_vld        (w_irqVld[g])
    );
  end

  // Map the channels onto the low bits of the PLIC buses; unused bits stay 0.
  always_comb begin
    o_pad_plic_int_vld              = '0;
    o_pad_plic_int_cfg              = '0;
    o_pad_plic_int_vld[N_IRQ-1:0]   = w_irqVld;
    o_pad_plic_int_cfg[N_IRQ-1:0]   = i_irq_pulse_mode;
  end

endmodule
